// File: rtl/ptw_arbiter_if.sv
// ptw_arbiter_if: bundle of every non-clock signal around the PTW arbiter.
//
// Handshake rules (all signals sampled on the rising clock edge):
//   - itlb_miss / dtlb_miss are requests. A requester holds miss and its
//     vaddr (and is_store) stable until it sees its ack high. The ack is
//     combinational and high for exactly one cycle. Dropping miss before
//     ack cancels the request, and no response follows.
//   - itlb_done / dtlb_done are one-cycle completion pulses for an
//     accepted request. err qualifies done. err is never high without done.
//   - ptw_access is a one-cycle walk-start pulse. ptw_vaddr, ptw_itlb_req and
//     ptw_is_store hold the latched request from that pulse until the next grant.
//   - ptw_update_valid, ptw_error and ptw_access_exception are PTW completion
//     strobes. ptw_active is the PTW busy level.
//
// Modports:
//   slave  - arbiter side (takes requests and PTW status, drives acks and pulses)
//   master - environment side (TLBs plus PTW model)
interface ptw_arbiter_if #(
    parameter int VLEN  = 39,
    parameter int CNT_W = 32
);
    logic             flush;
    logic             itlb_miss;
    logic [VLEN-1:0]  itlb_vaddr;
    logic             itlb_ack;
    logic             itlb_done;
    logic             itlb_err;
    logic             dtlb_miss;
    logic [VLEN-1:0]  dtlb_vaddr;
    logic             dtlb_is_store;
    logic             dtlb_ack;
    logic             dtlb_done;
    logic             dtlb_err;
    logic             ptw_access;
    logic [VLEN-1:0]  ptw_vaddr;
    logic             ptw_itlb_req;
    logic             ptw_is_store;
    logic             ptw_active;
    logic             ptw_update_valid;
    logic             ptw_error;
    logic             ptw_access_exception;
    logic             timeout;
    logic [CNT_W-1:0] itlb_miss_cnt;
    logic [CNT_W-1:0] dtlb_miss_cnt;

    modport slave (
        input  flush, itlb_miss, itlb_vaddr, dtlb_miss, dtlb_vaddr, dtlb_is_store,
               ptw_active, ptw_update_valid, ptw_error, ptw_access_exception,
        output itlb_ack, itlb_done, itlb_err, dtlb_ack, dtlb_done, dtlb_err,
               ptw_access, ptw_vaddr, ptw_itlb_req, ptw_is_store, timeout,
               itlb_miss_cnt, dtlb_miss_cnt
    );

    modport master (
        output flush, itlb_miss, itlb_vaddr, dtlb_miss, dtlb_vaddr, dtlb_is_store,
               ptw_active, ptw_update_valid, ptw_error, ptw_access_exception,
        input  itlb_ack, itlb_done, itlb_err, dtlb_ack, dtlb_done, dtlb_err,
               ptw_access, ptw_vaddr, ptw_itlb_req, ptw_is_store, timeout,
               itlb_miss_cnt, dtlb_miss_cnt
    );
endinterface

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: round-robin arbiter and sequencer between the ITLB/DTLB miss
// ports and a single page-table walker. One walk is outstanding at a time.
// The walk is watched until it completes, faults or times out. Then the
// arbiter waits for the PTW to go idle before the next grant.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   bus        - ptw_arbiter_if.slave (requests, responses, PTW side, counters)
//   dbg_state  - current FSM state (0 IDLE, 1 ISSUE, 2 WALK, 3 DRAIN)
module ptw_arbiter #(
    parameter int VLEN    = 39,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    ptw_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WALK  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             last_itlb_q;   // 1: ITLB won the previous grant
    logic [VLEN-1:0]  vaddr_q;
    logic             src_itlb_q;
    logic             is_store_q;
    logic [WD_W-1:0]  wd_q;
    logic [CNT_W-1:0] icnt_q, dcnt_q;
    logic             idone_q, ierr_q, ddone_q, derr_q, tmo_q;

    logic grant_i, grant_d, access;
    logic fin_done, fin_err, fin_tmo;
    logic wd_clr, wd_inc;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        access   = 1'b0;
        fin_done = 1'b0;
        fin_err  = 1'b0;
        fin_tmo  = 1'b0;
        wd_clr   = 1'b0;
        wd_inc   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.flush && !bus.ptw_active && (bus.itlb_miss || bus.dtlb_miss)) begin
                    // On a tie, the source that did not win last time gets the grant.
                    if (bus.dtlb_miss && (!bus.itlb_miss || last_itlb_q)) grant_d = 1'b1;
                    else                                                   grant_i = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_clr = 1'b1;
                // A flush here kills the walk before the PTW ever saw it.
                if (bus.flush) state_d = S_IDLE;
                else begin
                    access  = 1'b1;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (bus.flush) begin
                    // The PTW may still be running. Drain it, but report nothing.
                    wd_clr  = 1'b1;
                    state_d = S_DRAIN;
                end else if (bus.ptw_error || bus.ptw_access_exception) begin
                    fin_done = 1'b1;
                    fin_err  = 1'b1;
                    state_d  = S_DRAIN;
                end else if (bus.ptw_update_valid) begin
                    fin_done = 1'b1;
                    state_d  = S_DRAIN;
                end else if (wd_q == WD_LAST) begin
                    fin_done = 1'b1;
                    fin_err  = 1'b1;
                    fin_tmo  = 1'b1;
                    state_d  = S_DRAIN;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!bus.ptw_active) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Combinational outputs must stay quiet while reset is held.
        if (rst) begin
            grant_i = 1'b0;
            grant_d = 1'b0;
            access  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_itlb_q <= 1'b1;
            vaddr_q     <= '0;
            src_itlb_q  <= 1'b0;
            is_store_q  <= 1'b0;
            wd_q        <= '0;
            icnt_q      <= '0;
            dcnt_q      <= '0;
            idone_q     <= 1'b0;
            ierr_q      <= 1'b0;
            ddone_q     <= 1'b0;
            derr_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                vaddr_q     <= grant_i ? bus.itlb_vaddr : bus.dtlb_vaddr;
                src_itlb_q  <= grant_i;
                is_store_q  <= grant_d & bus.dtlb_is_store;
                last_itlb_q <= grant_i;
            end
            if (grant_i && (icnt_q != '1)) icnt_q <= icnt_q + CNT_W'(1);
            if (grant_d && (dcnt_q != '1)) dcnt_q <= dcnt_q + CNT_W'(1);
            if (wd_clr)      wd_q <= '0;
            else if (wd_inc) wd_q <= wd_q + WD_W'(1);
            idone_q <= fin_done &  src_itlb_q;
            ierr_q  <= fin_err  &  src_itlb_q;
            ddone_q <= fin_done & ~src_itlb_q;
            derr_q  <= fin_err  & ~src_itlb_q;
            tmo_q   <= fin_tmo;
        end
    end

    assign bus.itlb_ack      = grant_i;
    assign bus.dtlb_ack      = grant_d;
    assign bus.ptw_access    = access;
    assign bus.ptw_vaddr     = vaddr_q;
    assign bus.ptw_itlb_req  = src_itlb_q;
    assign bus.ptw_is_store  = is_store_q;
    assign bus.itlb_done     = idone_q;
    assign bus.itlb_err      = ierr_q;
    assign bus.dtlb_done     = ddone_q;
    assign bus.dtlb_err      = derr_q;
    assign bus.timeout       = tmo_q;
    assign bus.itlb_miss_cnt = icnt_q;
    assign bus.dtlb_miss_cnt = dcnt_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_ptw_arbiter.sv
// tb_ptw_arbiter: directed bench for ptw_arbiter (TIMEOUT=8, 4-bit counters).
module tb_ptw_arbiter;
    localparam int VLEN    = 39;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_icnt     = 0;
    int exp_dcnt     = 0;
    logic [0:0] exp_q[$];   // expected grant winners, 1 = ITLB, 0 = DTLB

    ptw_arbiter_if #(.VLEN(VLEN), .CNT_W(CNT_W)) bus ();

    ptw_arbiter #(.VLEN(VLEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: sim time limit hit, got running exp finished");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "bench time limit");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush                = 1'b0;
        bus.itlb_miss            = 1'b0;
        bus.itlb_vaddr           = '0;
        bus.dtlb_miss            = 1'b0;
        bus.dtlb_vaddr           = '0;
        bus.dtlb_is_store        = 1'b0;
        bus.ptw_active           = 1'b0;
        bus.ptw_update_valid     = 1'b0;
        bus.ptw_error            = 1'b0;
        bus.ptw_access_exception = 1'b0;
    endtask

    function automatic logic [4:0] resp_now();
        return {bus.itlb_done, bus.itlb_err, bus.dtlb_done, bus.dtlb_err, bus.timeout};
    endfunction

    // Called in the ack cycle. PTW model: busy from ISSUE, completes 3 cycles
    // after access, idles with the done cycle.
    // kind: 0 update, 1 page fault, 2 access exception, 3 fault+update.
    task automatic complete_walk(input logic use_itlb, input int kind,
                                 output logic [4:0] resp, output logic [4:0] resp_after);
        tick();
        if (use_itlb) bus.itlb_miss = 1'b0;
        else          bus.dtlb_miss = 1'b0;
        bus.ptw_active = 1'b1;
        tick();
        tick();
        tick();
        case (kind)
            0:       bus.ptw_update_valid = 1'b1;
            1:       bus.ptw_error = 1'b1;
            2:       bus.ptw_access_exception = 1'b1;
            default: begin
                bus.ptw_error        = 1'b1;
                bus.ptw_update_valid = 1'b1;
            end
        endcase
        tick();
        bus.ptw_update_valid     = 1'b0;
        bus.ptw_error            = 1'b0;
        bus.ptw_access_exception = 1'b0;
        bus.ptw_active           = 1'b0;
        resp = resp_now();
        tick();
        resp_after = resp_now();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst           = 1'b1;
        bus.itlb_miss = 1'b1;
        bus.dtlb_miss = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({bus.itlb_ack, bus.dtlb_ack} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ack: got %b exp 00", {bus.itlb_ack, bus.dtlb_ack});
        end
        idle_inputs();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({resp_now(), bus.ptw_access, bus.ptw_itlb_req, bus.ptw_is_store, bus.ptw_vaddr,
             bus.itlb_miss_cnt, bus.dtlb_miss_cnt, dbg_state} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got resp=%b acc=%b vaddr=%h icnt=%0d dcnt=%0d st=%0d exp all 0",
                     resp_now(), bus.ptw_access, bus.ptw_vaddr, bus.itlb_miss_cnt,
                     bus.dtlb_miss_cnt, dbg_state);
        end
    endtask

    task automatic test_single_itlb();
        logic [VLEN-1:0] va;
        va = 39'h40_0000_1000;
        bus.itlb_vaddr = va;
        bus.itlb_miss  = 1'b1;
        #1;
        tests_run++;
        if ({bus.itlb_ack, bus.dtlb_ack} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_ack: got %b exp 10", {bus.itlb_ack, bus.dtlb_ack});
        end
        exp_icnt++;
        tick();  // cycle 1
        bus.itlb_miss  = 1'b0;
        bus.ptw_active = 1'b1;
        tests_run++;
        if ({bus.ptw_access, bus.ptw_itlb_req, bus.ptw_is_store} !== 3'b110 || bus.ptw_vaddr !== va) begin
            tests_failed++;
            $display("FAIL single_issue: got acc/req/st=%b vaddr=%h exp 110 %h",
                     {bus.ptw_access, bus.ptw_itlb_req, bus.ptw_is_store}, bus.ptw_vaddr, va);
        end
        tests_run++;
        if (bus.itlb_miss_cnt !== CNT_W'(exp_icnt)) begin
            tests_failed++;
            $display("FAIL single_cnt: got %0d exp %0d", bus.itlb_miss_cnt, exp_icnt);
        end
        tick();  // cycle 2
        tests_run++;
        if (bus.ptw_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_access_width: got %b exp 0", bus.ptw_access);
        end
        tick();  // cycle 3
        tick();  // cycle 4
        bus.ptw_update_valid = 1'b1;
        tests_run++;
        if (resp_now() !== 5'b00000) begin
            tests_failed++;
            $display("FAIL single_early_done: got %b exp 00000", resp_now());
        end
        tick();  // cycle 5
        bus.ptw_update_valid = 1'b0;
        bus.ptw_active       = 1'b0;
        tests_run++;
        if (resp_now() !== 5'b10000) begin
            tests_failed++;
            $display("FAIL single_done: got %b exp 10000", resp_now());
        end
        tick();  // cycle 6
        tests_run++;
        if (resp_now() !== 5'b00000 || dbg_state !== 2'd0 || bus.ptw_vaddr !== va) begin
            tests_failed++;
            $display("FAIL single_after: got resp=%b st=%0d vaddr=%h exp 00000 0 %h",
                     resp_now(), dbg_state, bus.ptw_vaddr, va);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] r, ra;
        logic [0:0] winner;
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        // first tie after reset: DTLB (store) wins
        bus.itlb_vaddr    = 39'h11000;
        bus.dtlb_vaddr    = 39'h22000;
        bus.dtlb_is_store = 1'b1;
        bus.itlb_miss     = 1'b1;
        bus.dtlb_miss     = 1'b1;
        #1;
        winner = bus.itlb_ack;
        tests_run++;
        if ((bus.itlb_ack ^ bus.dtlb_ack) !== 1'b1 || winner !== exp_q.pop_front()) begin
            tests_failed++;
            $display("FAIL rr_tie1: got i/d ack %b%b exp 01", bus.itlb_ack, bus.dtlb_ack);
        end
        exp_dcnt++;
        tick();
        bus.dtlb_miss  = 1'b0;
        bus.ptw_active = 1'b1;
        tests_run++;
        if ({bus.ptw_access, bus.ptw_itlb_req, bus.ptw_is_store, bus.itlb_ack} !== 4'b1010 ||
            bus.ptw_vaddr !== 39'h22000) begin
            tests_failed++;
            $display("FAIL rr_dtlb_issue: got acc/req/st/iack=%b vaddr=%h exp 1010 22000",
                     {bus.ptw_access, bus.ptw_itlb_req, bus.ptw_is_store, bus.itlb_ack}, bus.ptw_vaddr);
        end
        tick();
        tick();
        bus.ptw_update_valid = 1'b1;
        tick();
        bus.ptw_update_valid = 1'b0;
        tests_run++;
        if (resp_now() !== 5'b00100) begin
            tests_failed++;
            $display("FAIL rr_dtlb_done: got %b exp 00100", resp_now());
        end
        tick();  // PTW still busy: DRAIN holds
        tests_run++;
        if (bus.itlb_ack !== 1'b0 || dbg_state !== 2'd3) begin
            tests_failed++;
            $display("FAIL rr_drain_hold: got ack=%b st=%0d exp 0 3", bus.itlb_ack, dbg_state);
        end
        bus.ptw_active = 1'b0;
        #1;
        tests_run++;
        if (bus.itlb_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_drain_exit_nogrant: got %b exp 0", bus.itlb_ack);
        end
        tick();
        winner = bus.itlb_ack;
        tests_run++;
        if ((bus.itlb_ack ^ bus.dtlb_ack) !== 1'b1 || winner !== exp_q.pop_front()) begin
            tests_failed++;
            $display("FAIL rr_itlb_grant: got i/d ack %b%b exp 10", bus.itlb_ack, bus.dtlb_ack);
        end
        exp_icnt++;
        complete_walk(1'b1, 0, r, ra);
        tests_run++;
        if (r !== 5'b10000 || ra !== 5'b00000 || bus.ptw_is_store !== 1'b0 || bus.ptw_itlb_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_itlb_walk: got resp=%b after=%b st=%b req=%b exp 10000 00000 0 1",
                     r, ra, bus.ptw_is_store, bus.ptw_itlb_req);
        end
        // second tie: ITLB went last, so DTLB wins again
        bus.itlb_miss = 1'b1;
        bus.dtlb_miss = 1'b1;
        #1;
        winner = bus.itlb_ack;
        tests_run++;
        if ((bus.itlb_ack ^ bus.dtlb_ack) !== 1'b1 || winner !== exp_q.pop_front()) begin
            tests_failed++;
            $display("FAIL rr_tie2: got i/d ack %b%b exp 01", bus.itlb_ack, bus.dtlb_ack);
        end
        exp_dcnt++;
        complete_walk(1'b0, 0, r, ra);
        // ITLB is still pending and should win straight after the drain
        tests_run++;
        if (r !== 5'b00100 || bus.itlb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL rr_tie2_walk: got resp=%b iack=%b exp 00100 1", r, bus.itlb_ack);
        end
        exp_icnt++;
        complete_walk(1'b1, 0, r, ra);
        tests_run++;
        if (bus.itlb_miss_cnt !== CNT_W'(exp_icnt) || bus.dtlb_miss_cnt !== CNT_W'(exp_dcnt)) begin
            tests_failed++;
            $display("FAIL rr_counts: got i=%0d d=%0d exp i=%0d d=%0d",
                     bus.itlb_miss_cnt, bus.dtlb_miss_cnt, exp_icnt, exp_dcnt);
        end
    endtask

    task automatic test_errors();
        logic [4:0] r, ra;
        bus.dtlb_vaddr    = 39'h7_0000_3000;
        bus.dtlb_is_store = 1'b0;
        bus.dtlb_miss     = 1'b1;
        #1;
        tests_run++;
        if (bus.dtlb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL exc_ack: got %b exp 1", bus.dtlb_ack);
        end
        exp_dcnt++;
        complete_walk(1'b0, 2, r, ra);
        tests_run++;
        if (r !== 5'b00110 || ra !== 5'b00000) begin
            tests_failed++;
            $display("FAIL exc_resp: got %b then %b exp 00110 then 00000", r, ra);
        end
        // fault and update together: the fault wins
        bus.itlb_vaddr = 39'h5000;
        bus.itlb_miss  = 1'b1;
        #1;
        tests_run++;
        if (bus.itlb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL errprio_ack: got %b exp 1", bus.itlb_ack);
        end
        exp_icnt++;
        complete_walk(1'b1, 3, r, ra);
        tests_run++;
        if (r !== 5'b11000 || ra !== 5'b00000) begin
            tests_failed++;
            $display("FAIL errprio_resp: got %b then %b exp 11000 then 00000", r, ra);
        end
    endtask

    task automatic test_timeout();
        logic [4:0] r, ra;
        bus.dtlb_vaddr = 39'h9000;
        bus.dtlb_miss  = 1'b1;
        #1;
        tests_run++;
        if (bus.dtlb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_ack: got %b exp 1", bus.dtlb_ack);
        end
        exp_dcnt++;
        tick();  // ISSUE
        bus.dtlb_miss  = 1'b0;
        bus.ptw_active = 1'b1;
        tick();  // WALK entry
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        tests_run++;
        if (resp_now() !== 5'b00000) begin
            tests_failed++;
            $display("FAIL tmo_early: got %b exp 00000", resp_now());
        end
        tick();  // WALK entry + TIMEOUT
        tests_run++;
        if (resp_now() !== 5'b00111) begin
            tests_failed++;
            $display("FAIL tmo_pulse: got %b exp 00111", resp_now());
        end
        bus.itlb_vaddr = 39'hA000;
        bus.itlb_miss  = 1'b1;
        tick();
        tests_run++;
        if (resp_now() !== 5'b00000 || bus.itlb_ack !== 1'b0 || dbg_state !== 2'd3) begin
            tests_failed++;
            $display("FAIL tmo_drain: got resp=%b ack=%b st=%0d exp 00000 0 3",
                     resp_now(), bus.itlb_ack, dbg_state);
        end
        tick();
        bus.ptw_active = 1'b0;
        #1;
        tests_run++;
        if (bus.itlb_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL tmo_drain_exit: got %b exp 0", bus.itlb_ack);
        end
        tick();
        tests_run++;
        if (bus.itlb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_next_grant: got %b exp 1", bus.itlb_ack);
        end
        exp_icnt++;
        complete_walk(1'b1, 0, r, ra);
        tests_run++;
        if (r !== 5'b10000) begin
            tests_failed++;
            $display("FAIL tmo_next_walk: got %b exp 10000", r);
        end
    endtask

    task automatic test_flush();
        logic [4:0] r, ra;
        logic [4:0] seen;
        // flush during WALK together with update
        bus.itlb_miss = 1'b1;
        #1;
        exp_icnt++;
        tick();
        bus.itlb_miss  = 1'b0;
        bus.ptw_active = 1'b1;
        tick();
        tick();
        bus.ptw_update_valid = 1'b1;
        bus.flush            = 1'b1;
        tick();
        bus.ptw_update_valid = 1'b0;
        bus.flush            = 1'b0;
        tests_run++;
        if (resp_now() !== 5'b00000 || dbg_state !== 2'd3) begin
            tests_failed++;
            $display("FAIL flush_walk: got resp=%b st=%0d exp 00000 3", resp_now(), dbg_state);
        end
        bus.dtlb_vaddr = 39'hB000;
        bus.dtlb_miss  = 1'b1;
        tick();
        tests_run++;
        if (resp_now() !== 5'b00000 || bus.dtlb_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_drain_hold: got resp=%b ack=%b exp 00000 0", resp_now(), bus.dtlb_ack);
        end
        bus.ptw_active = 1'b0;
        tick();
        tests_run++;
        if (bus.dtlb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_next_grant: got %b exp 1", bus.dtlb_ack);
        end
        exp_dcnt++;
        complete_walk(1'b0, 0, r, ra);
        tests_run++;
        if (r !== 5'b00100) begin
            tests_failed++;
            $display("FAIL flush_next_walk: got %b exp 00100", r);
        end
        // flush during ISSUE
        bus.itlb_miss = 1'b1;
        #1;
        exp_icnt++;
        tick();
        bus.itlb_miss = 1'b0;
        bus.flush     = 1'b1;
        #1;
        tests_run++;
        if (bus.ptw_access !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_issue_access: got %b exp 0", bus.ptw_access);
        end
        tick();
        bus.flush = 1'b0;
        seen = 5'b00000;
        for (int i = 0; i < 4; i++) begin
            seen = seen | resp_now();
            tick();
        end
        tests_run++;
        if (seen !== 5'b00000 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL flush_issue_quiet: got resp=%b st=%0d exp 00000 0", seen, dbg_state);
        end
        // flush in IDLE blocks grant
        bus.flush     = 1'b1;
        bus.itlb_miss = 1'b1;
        #1;
        tests_run++;
        if (bus.itlb_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle_block: got %b exp 0", bus.itlb_ack);
        end
        bus.flush = 1'b0;
        #1;
        tests_run++;
        if (bus.itlb_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_idle_release: got %b exp 1", bus.itlb_ack);
        end
        exp_icnt++;
        complete_walk(1'b1, 0, r, ra);
    endtask

    task automatic test_saturation();
        logic [4:0] r, ra;
        int acks_missing;
        acks_missing = 0;
        for (int n = 0; n < 10; n++) begin
            bus.itlb_miss = 1'b1;
            #1;
            if (bus.itlb_ack !== 1'b1) acks_missing++;
            exp_icnt = (exp_icnt >= 15) ? 15 : exp_icnt + 1;
            complete_walk(1'b1, 0, r, ra);
        end
        tests_run++;
        if (acks_missing != 0) begin
            tests_failed++;
            $display("FAIL sat_acks: got %0d missing acks exp 0", acks_missing);
        end
        tests_run++;
        if (bus.itlb_miss_cnt !== CNT_W'(exp_icnt) || exp_icnt != 15) begin
            tests_failed++;
            $display("FAIL sat_icnt: got %0d exp %0d (all-ones 15)", bus.itlb_miss_cnt, exp_icnt);
        end
        bus.itlb_miss = 1'b1;
        #1;
        complete_walk(1'b1, 0, r, ra);
        tests_run++;
        if (bus.itlb_miss_cnt !== 4'hF || bus.dtlb_miss_cnt !== CNT_W'(exp_dcnt)) begin
            tests_failed++;
            $display("FAIL sat_hold: got i=%0d d=%0d exp i=15 d=%0d",
                     bus.itlb_miss_cnt, bus.dtlb_miss_cnt, exp_dcnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_itlb();
        test_back_to_back();
        test_errors();
        test_timeout();
        test_flush();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
